// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_adder.sv
// 4-bit combinational ripple-carry adder slice.
module ripple_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    S      = '0;
    w_c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      S[i]     = A[i] ^ B[i] ^ w_c[i];
      w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    Cout = w_c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice, LS nibble first, registered carry between nibbles.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t             r_state, w_state_d;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry, r_cout;
  logic [NIBBLE_W-1:0] w_s;
  logic               w_cout;

  ripple_adder u_ripple_adder (
    .S    (w_s),
    .Cout (w_cout),
    .A    (r_a[NIBBLE_W-1:0]),
    .B    (r_b[NIBBLE_W-1:0]),
    .Cin  (r_carry)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid) w_state_d = ST_ADD;
      ST_ADD:  if (r_cnt == LAST_CNT) w_state_d = ST_DONE;
      ST_DONE: if (out_ready) w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        ST_ADD: begin
          // New nibble enters at the top; after NIBBLES shifts nibble k sits at [4k+3:4k].
          r_sum   <= {w_s, r_sum[WIDTH-1:NIBBLE_W]};
          r_a     <= {{NIBBLE_W{1'b0}}, r_a[WIDTH-1:NIBBLE_W]};
          r_b     <= {{NIBBLE_W{1'b0}}, r_b[WIDTH-1:NIBBLE_W]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_cout <= w_cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: driver pushes expected results, monitor pops on handshake.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;
  bit prev_v = 1'b0;

  logic [16:0] exp_q[$];
  int          lat_q[$];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on out_valid rise, data on each handshake.
  always @(negedge clk) begin
    logic [16:0] e;
    int l;
    if (!rst) begin
      if (out_valid && !prev_v) begin
        if (lat_q.size() == 0) chk("latency_unexpected", 1, 0);
        else begin
          l = lat_q.pop_front();
          chk("latency", 32'(cyc - l), 4);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(e[15:0]));
          chk("cout", 32'(cout), 32'(e[16]));
        end
      end
    end
    prev_v = out_valid;
  end

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input bit track);
    bit ok = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else if (track) begin
      exp_q.push_back(17'(ta) + 17'(tb) + 17'(tc));
      lat_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    logic [15:0] hs;
    logic        hc;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    @(negedge clk); rst = 1'b0;

    // Plain add, then in_ready the cycle after the output handshake.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1);
    wait_drain();
    @(posedge clk); #1;
    chk("in_ready_after_hs", 32'(in_ready), 1);
    chk("out_valid_after_hs", 32'(out_valid), 0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_drain();
    do_op(16'h0FFF, 16'h0000, 1'b1, 1'b1);
    wait_drain();
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    wait_drain();

    // Backpressure in DONE with in_valid toggling.
    out_ready = 1'b0;
    do_op(16'h8001, 16'h8002, 1'b1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bp_valid_timeout", 0, 1);
    hs = sum; hc = cout;
    chk("bp_sum_expected", 32'(hs), 32'h0004);
    chk("bp_cout_expected", 32'(hc), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; a = 16'h5A5A + 16'(i); b = 16'h0F0F; cin = 1'b1;
      @(negedge clk);
      chk("bp_sum_stable", 32'(sum), 32'(hs));
      chk("bp_cout_stable", 32'(cout), 32'(hc));
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    @(posedge clk); #1;
    chk("bp_idle_in_ready", 32'(in_ready), 1);
    chk("bp_idle_out_valid", 32'(out_valid), 0);

    // Reset two nibbles into an add.
    do_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(negedge clk); rst = 1'b0;
    do_op(16'h0001, 16'h0002, 1'b0, 1'b1);
    wait_drain();

    // Random back-to-back with output stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
